br_lite_ni: RTL
===============

# br_lite_ni

Local network interface between a processing element (PE) and the LOCAL port of a BrLite router.
- **TX path:** takes single-word broadcast/target requests from the PE, builds a `br_data_t` flit with this node's source address and a sequence id, and injects it through the router's LOCAL input with the 4-phase req/ack handshake.
- **RX path:** accepts flits from the router's LOCAL output with the same handshake and queues them in a FWFT FIFO for the PE.

## Interface
- `ADDRESS`, 0: 16-bit node address placed in `source`.
- `RX_DEPTH`, 4: RX FIFO depth; must be a power of 2 and ≥2.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-high.
  - `clk_i`, in, 1: clock.
  - `rst_i`, in, 1: asynchronous active-high reset.
- PE TX interface:
  - `tx_valid_i`, in, 1: PE request valid.
  - `tx_ready_o`, out, 1: request accepted when both valid and ready are high.
  - `tx_service_i`, in, `br_svc_t`: requested service, BR_SVC_ALL or BR_SVC_TGT.
  - `tx_target_i`, in, 16: target address.
  - `tx_payload_i`, in, payload width of `br_data_t`: payload.
- Router LOCAL input side:
  - `br_req_o`, out, 1: request to router `req_i[LOCAL]`.
  - `br_ack_i`, in, 1: from router `ack_o[LOCAL]`.
  - `br_flit_o`, out, `br_data_t`: to router `flit_i[LOCAL]`.
  - `br_busy_i`, in, 1: from router `local_busy_o`.
- Router LOCAL output side:
  - `br_req_i`, in, 1: from router `req_o[LOCAL]`.
  - `br_ack_o`, out, 1: to router `ack_i[LOCAL]`.
  - `br_flit_i`, in, `br_data_t`: from router `flit_o[LOCAL]`.
- PE RX interface:
  - `rx_valid_o`, out, 1: FIFO head valid.
  - `rx_ready_i`, in, 1: PE pops the head when both are high.
  - `rx_data_o`, out, `br_data_t`: FIFO head (FWFT).
  - `rx_clear_cnt_o`, out, 8: saturating count of discarded BR_SVC_CLEAR flits.

## Operation
TX FSM, states TX_IDLE, TX_REQ, TX_WAIT:
- `tx_ready_o` = (state == TX_IDLE) && !`br_busy_i` (combinational).
- TX_IDLE, on accept with service ALL or TGT:
  - Register `br_flit_o` = {source=ADDRESS, target=`tx_target_i`, service, payload, id=`id_cnt`}.
  - Set `br_req_o`; go to TX_REQ.
- TX_IDLE, on accept with any other service: discard the request, leave `id_cnt` unchanged, stay in TX_IDLE.
- TX_REQ: hold `br_req_o` and `br_flit_o`. On `br_ack_i`=1: clear `br_req_o`, increment `id_cnt` (wraps modulo the id field width), go to TX_WAIT.
- TX_WAIT: on `br_ack_i`=0, go to TX_IDLE.
- Router drops with CAM full (no ack): keep `br_req_o` high indefinitely; the router retries.
- Only one local broadcast is outstanding per router. `br_busy_i` rises before the router acks, so a new accept is blocked until the router clears it.

RX FSM, states RX_IDLE, RX_ACK:
- RX_IDLE, `br_req_i`=1, flit service ≠ BR_SVC_CLEAR, FIFO count < RX_DEPTH (count sampled at the start of the cycle): push `br_flit_i`, set `br_ack_o`, go to RX_ACK.
- RX_IDLE, `br_req_i`=1, flit service = BR_SVC_CLEAR: do not push; increment `rx_clear_cnt_o` (saturates at 255); set `br_ack_o`; go to RX_ACK.
- RX_IDLE, `br_req_i`=1, FIFO full: no ack; wait (backpressure).
- RX_ACK: hold `br_ack_o`=1 until `br_req_i`=0, then clear `br_ack_o` and go to RX_IDLE.
- The flit is captured exactly once per handshake.

RX FIFO:
- `rx_valid_o` = count ≠ 0; `rx_data_o` = head entry.
- Pop on `rx_valid_o` && `rx_ready_i`.
- Push and pop in the same cycle: count is unchanged. When the FIFO is full, a same-cycle pop does not enable a push; the push happens the next cycle.
- Read and write pointers are log2(RX_DEPTH) bits and wrap naturally; count is log2(RX_DEPTH)+1 bits.

## Timing
- Reset values: `br_req_o`=0, `br_ack_o`=0, `br_flit_o`=0, `rx_clear_cnt_o`=0, `id_cnt`=0, FIFO empty (`rx_valid_o`=0), both FSMs in IDLE.
- `tx_ready_o` is 1 after reset unless `br_busy_i`=1.
- Reset asserted mid-handshake: all of the above return to reset values immediately; an in-flight flit is lost.
- TX: accept at edge N → `br_req_o`=1 after N. `br_ack_i` sampled 1 at edge M → `br_req_o`=0 after M. `br_ack_i` sampled 0 at edge K → TX_IDLE after K; a new accept is possible at K+1 if `br_busy_i`=0.
- RX: `br_req_i` sampled 1 at edge N with space → `br_ack_o`=1 and `rx_valid_o`=1 after N. `br_req_i` sampled 0 at edge M → `br_ack_o`=0 after M.
- All outputs are registered except `tx_ready_o`, `rx_valid_o` and `rx_data_o`.

## Test plan
- Reset, then TGT request (target 0x0102, payload 0xCAFE) with ADDRESS=0x0001 → `br_flit_o`={src 0x0001, tgt 0x0102, TGT, id 0}; `br_req_o` high until `br_ack_i` rises and low one cycle later; next flit uses id 1.
- Hold `br_busy_i`=1 with `tx_valid_i`=1 → `tx_ready_o`=0 and no `br_req_o`. Release `br_busy_i` → accept occurs on the next edge.
- Router withholds ack for 50 cycles (CAM full) → `br_req_o` and `br_flit_o` stay stable throughout; completes normally when ack arrives.
- Five router deliveries with `rx_ready_i`=0 and RX_DEPTH=4 → four acks; fifth `br_req_i` unacked until one pop, then acked; PE reads all five flits in order.
- Router delivers a BR_SVC_CLEAR flit → acked, not queued, `rx_clear_cnt_o` 0→1; 300 CLEAR flits → counter reads 255.
- Assert `rst_i` while in TX_REQ with two FIFO entries → `br_req_o`=0, `rx_valid_o`=0, `id_cnt`=0 immediately (asynchronously).

Source files
------------

// File: rtl/br_lite_ni.sv
// BrLite local network interface: PE requests become router flits on the TX side;
// router deliveries are queued in a first-word-fall-through FIFO on the RX side.
package br_lite_pkg;
  localparam int ADDR_W    = 16;
  localparam int PAYLOAD_W = 16;
  localparam int ID_W      = 8;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_MON   = 2'd3
  } br_svc_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    source;
    logic [ADDR_W-1:0]    target;
    br_svc_t              service;
    logic [PAYLOAD_W-1:0] payload;
    logic [ID_W-1:0]      id;
  } br_data_t;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_WAIT = 2'd2} tx_state_e;
  typedef enum logic {RX_IDLE = 1'b0, RX_ACK = 1'b1} rx_state_e;
endpackage

// Handshakes: PE side uses valid/ready (transfer on the edge where both are high,
// no combinational path from valid to ready); router side uses 4-phase req/ack
// (req rises, ack rises, req falls, ack falls, one transfer per cycle of the four).
module br_lite_ni
  import br_lite_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDRESS  = '0,
  parameter int                RX_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  br_svc_t              tx_service_i,
  input  logic [ADDR_W-1:0]    tx_target_i,
  input  logic [PAYLOAD_W-1:0] tx_payload_i,
  output logic                 br_req_o,
  input  logic                 br_ack_i,
  output br_data_t             br_flit_o,
  input  logic                 br_busy_i,
  input  logic                 br_req_i,
  output logic                 br_ack_o,
  input  br_data_t             br_flit_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output br_data_t             rx_data_o,
  output logic [7:0]           rx_clear_cnt_o,
  output tx_state_e            tx_state_o,
  output rx_state_e            rx_state_o
);
  localparam int AW    = $clog2(RX_DEPTH);
  localparam int CNT_W = AW + 1;

  tx_state_e            tx_state_q, tx_state_d;
  logic                 br_req_q, br_req_d;
  br_data_t             br_flit_q, br_flit_d;
  logic [ID_W-1:0]      id_cnt_q, id_cnt_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 br_ack_q, br_ack_d;
  logic [7:0]           clr_cnt_q, clr_cnt_d;

  br_data_t             mem_q [RX_DEPTH];
  br_data_t             mem_d [RX_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push;
  logic                 pop;

  assign tx_ready_o     = (tx_state_q == TX_IDLE) && !br_busy_i;
  assign br_req_o       = br_req_q;
  assign br_flit_o      = br_flit_q;
  assign br_ack_o       = br_ack_q;
  assign rx_clear_cnt_o = clr_cnt_q;
  assign rx_valid_o     = (count_q != '0);
  assign rx_data_o      = mem_q[rd_ptr_q];
  assign pop            = rx_valid_o && rx_ready_i;
  assign tx_state_o     = tx_state_q;
  assign rx_state_o     = rx_state_q;

  always_comb begin
    tx_state_d = tx_state_q;
    br_req_d   = br_req_q;
    br_flit_d  = br_flit_q;
    id_cnt_d   = id_cnt_q;
    case (tx_state_q)
      TX_IDLE: begin
        // Services other than ALL/TGT are swallowed without consuming an id.
        if (tx_valid_i && tx_ready_o &&
            (tx_service_i == BR_SVC_ALL || tx_service_i == BR_SVC_TGT)) begin
          br_flit_d.source  = ADDRESS;
          br_flit_d.target  = tx_target_i;
          br_flit_d.service = tx_service_i;
          br_flit_d.payload = tx_payload_i;
          br_flit_d.id      = id_cnt_q;
          br_req_d          = 1'b1;
          tx_state_d        = TX_REQ;
        end
      end
      TX_REQ: begin
        if (br_ack_i) begin
          br_req_d   = 1'b0;
          id_cnt_d   = id_cnt_q + 1'b1;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!br_ack_i) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    br_ack_d   = br_ack_q;
    clr_cnt_d  = clr_cnt_q;
    push       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (br_req_i) begin
          if (br_flit_i.service == BR_SVC_CLEAR) begin
            if (clr_cnt_q != 8'hFF) clr_cnt_d = clr_cnt_q + 8'd1;
            br_ack_d   = 1'b1;
            rx_state_d = RX_ACK;
          end else if (count_q < CNT_W'(RX_DEPTH)) begin
            // Uses the registered count, so a pop this cycle cannot free a slot.
            push       = 1'b1;
            br_ack_d   = 1'b1;
            rx_state_d = RX_ACK;
          end
        end
      end
      RX_ACK: begin
        if (!br_req_i) begin
          br_ack_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = br_flit_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      br_req_q   <= 1'b0;
      br_flit_q  <= '0;
      id_cnt_q   <= '0;
      rx_state_q <= RX_IDLE;
      br_ack_q   <= 1'b0;
      clr_cnt_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      br_req_q   <= br_req_d;
      br_flit_q  <= br_flit_d;
      id_cnt_q   <= id_cnt_d;
      rx_state_q <= rx_state_d;
      br_ack_q   <= br_ack_d;
      clr_cnt_q  <= clr_cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule
